// File: rtl/accum_sequencer.sv
// accum_sequencer: Moore micro-sequencer expanding 3-bit commands into A/B load and bus-enable sequences.
// Optional FLAG_LATCH_EN builds cf_q/zf_q registers that capture the ALU flags at the end of ADD/SUB.
module accum_sequencer #(
  parameter int OUT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic       alu_cf,
  input  logic       alu_zf,
  output logic       nLa,
  output logic       nLb,
  output logic       Ea,
  output logic       Eu,
  output logic       sub,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       cf_q,
  output logic       zf_q
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EXEC1 = 3'd1,
    EXEC2 = 3'd2,
    OUTP  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_LDA = 3'd1;
  localparam logic [2:0] OP_LDB = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_OUT = 3'd5;

  // OUTP counts down from OUT_CYCLES-1 to 0, giving exactly OUT_CYCLES cycles of Ea.
  localparam logic [7:0] OUT_LOAD = 8'(OUT_CYCLES - 1);

  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic logic is_illegal(input logic [2:0] op);
    return op > OP_OUT;
  endfunction

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] op_q;
  logic       ready_q;
  logic       err_q;
  logic       accept;

  // ready is registered so no input reaches cmd_ready combinationally.
  assign accept    = cmd_valid && ready_q;
  assign cmd_ready = ready_q;
  assign err       = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nLa     = 1'b1;
    nLb     = 1'b1;
    Ea      = 1'b0;
    Eu      = 1'b0;
    sub     = 1'b0;
    done    = 1'b0;
    busy    = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_LDA, OP_LDB, OP_ADD, OP_SUB: state_d = EXEC1;
            OP_OUT: begin
              state_d = OUTP;
              cnt_d   = OUT_LOAD;
            end
            default: state_d = DONE;
          endcase
        end
      end
      EXEC1: begin
        nLa = !(op_q == OP_LDA);
        nLb = !(op_q == OP_LDB);
        Eu  = is_arith(op_q);
        sub = (op_q == OP_SUB);
        state_d = is_arith(op_q) ? EXEC2 : DONE;
      end
      EXEC2: begin
        // Result is written back into A while the ALU still drives the bus.
        nLa     = 1'b0;
        Eu      = 1'b1;
        sub     = (op_q == OP_SUB);
        state_d = DONE;
      end
      OUTP: begin
        Ea = 1'b1;
        if (cnt_q == 8'd0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == IDLE);
      if (accept && is_illegal(cmd_op)) begin
        err_q <= 1'b1;
      end
    end
  end

  // Opcode register is datapath-like: only meaningful after an accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q <= cmd_op;
    end
  end

`ifdef FLAG_LATCH_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cf_q <= 1'b0;
      zf_q <= 1'b0;
    end else if (state_q == EXEC2) begin
      cf_q <= alu_cf;
      zf_q <= alu_zf;
    end
  end
`else
  assign cf_q = 1'b0;
  assign zf_q = 1'b0;
  logic unused_alu_flags;
  assign unused_alu_flags = ^{alu_cf, alu_zf, OP_NOP};
`endif

`ifndef SYNTHESIS
  // Bus contention, dual-load and stray subtract checks.
  a_bus_excl: assert property (@(posedge clk) disable iff (rst) !(Ea && Eu));
  a_load_excl: assert property (@(posedge clk) disable iff (rst) (nLa || nLb));
  a_sub_in_alu: assert property (@(posedge clk) disable iff (rst) (!sub || Eu));
`endif

endmodule

// File: tb/tb_accum_sequencer.sv
// Self-checking bench for accum_sequencer: directed scenarios followed by random traffic,
// compared cycle by cycle against a command-to-control-sequence expansion model.
module tb_accum_sequencer;
  localparam int OUT_CYCLES = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_op = 3'd0;
  logic       alu_cf = 1'b0;
  logic       alu_zf = 1'b0;
  logic       cmd_ready, nLa, nLb, Ea, Eu, sub, busy, done, err, cf_q, zf_q;

  accum_sequencer #(.OUT_CYCLES(OUT_CYCLES)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .alu_cf(alu_cf), .alu_zf(alu_zf), .nLa(nLa), .nLb(nLb), .Ea(Ea), .Eu(Eu), .sub(sub),
    .busy(busy), .done(done), .err(err), .cf_q(cf_q), .zf_q(zf_q)
  );

  always #5 clk = ~clk;

  // One entry per busy cycle the command will occupy; empty queue means idle.
  typedef struct packed {
    logic nla, nlb, ea, eu, sub, done, cap;
  } frame_t;

  frame_t q[$];
  logic ready_m = 1'b0, err_m = 1'b0, cf_m = 1'b0, zf_m = 1'b0, acc_m = 1'b0;
  int   n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h, want %h", tag, $time, obs, exp);
    end
  endtask

  task automatic expand(input logic [2:0] op);
    frame_t base, f;
    base = '{nla: 1'b1, nlb: 1'b1, ea: 1'b0, eu: 1'b0, sub: 1'b0, done: 1'b0, cap: 1'b0};
    f = base;
    case (op)
      3'd1: begin f.nla = 1'b0; q.push_back(f); end
      3'd2: begin f.nlb = 1'b0; q.push_back(f); end
      3'd3, 3'd4: begin
        f.eu = 1'b1; f.sub = (op == 3'd4); q.push_back(f);
        f.nla = 1'b0; f.cap = 1'b1; q.push_back(f);
      end
      3'd5: begin f.ea = 1'b1; repeat (OUT_CYCLES) q.push_back(f); end
      default: ;
    endcase
    f = base; f.done = 1'b1; q.push_back(f);
    if (op > 3'd5) err_m = 1'b1;
  endtask

  task automatic model_edge();
    acc_m = 1'b0;
    if (rst) begin
      q.delete();
      ready_m = 1'b0; err_m = 1'b0; cf_m = 1'b0; zf_m = 1'b0;
    end else begin
      if (q.size() > 0) begin
`ifdef FLAG_LATCH_EN
        if (q[0].cap) begin cf_m = alu_cf; zf_m = alu_zf; end
`endif
        q.delete(0);
      end else if (ready_m && cmd_valid) begin
        acc_m = 1'b1;
        expand(cmd_op);
      end
      ready_m = (q.size() == 0);
    end
  endtask

  function automatic logic [10:0] exp_vec();
    if (q.size() > 0)
      return {1'b0, q[0].nla, q[0].nlb, q[0].ea, q[0].eu, q[0].sub, 1'b1, q[0].done, err_m, cf_m, zf_m};
    return {ready_m, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, err_m, cf_m, zf_m};
  endfunction

  task automatic step(input string tag, input logic r, input logic v, input logic [2:0] op,
                      input logic cf, input logic zf);
    @(negedge clk);
    chk(tag, 16'({cmd_ready, nLa, nLb, Ea, Eu, sub, busy, done, err, cf_q, zf_q}), 16'(exp_vec()));
    chk({tag, "_ea_eu"}, 16'(Ea & Eu), 16'd0);
    chk({tag, "_nla_nlb"}, 16'(!nLa && !nLb), 16'd0);
    rst = r; cmd_valid = v; cmd_op = op; alu_cf = cf; alu_zf = zf;
    @(posedge clk);
    model_edge();
  endtask

  task automatic send(input string tag, input logic [2:0] op, input logic cf, input logic zf,
                      output int cycles);
    cycles = 0;
    do begin
      step(tag, 1'b0, 1'b1, op, cf, zf);
      cycles++;
    end while (!acc_m && cycles < 50);
    if (!acc_m) chk({tag, "_accept_timeout"}, 16'd0, 16'd1);
  endtask

  task automatic idle(input string tag, input int n, input logic cf, input logic zf);
    repeat (n) step(tag, 1'b0, 1'b0, 3'd0, cf, zf);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) @(posedge clk);
    step("reset", 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    step("reset", 1'b1, 1'b1, 3'd3, 1'b0, 1'b0);
    step("rst_fall", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    idle("idle", 2, 1'b0, 1'b0);

    send("lda", 3'd1, 1'b0, 1'b0, n);
    send("ldb", 3'd2, 1'b0, 1'b0, n);
    chk("lda_ldb_gap", 16'(n), 16'd3);
    idle("ldb_tail", 3, 1'b0, 1'b0);

    send("sub", 3'd4, 1'b1, 1'b1, n);
    idle("sub_tail", 5, 1'b1, 1'b1);
    send("add_flags", 3'd3, 1'b0, 1'b1, n);
    idle("add_tail", 5, 1'b0, 1'b1);

    send("out", 3'd5, 1'b0, 1'b0, n);
    idle("out_tail", OUT_CYCLES + 3, 1'b0, 1'b0);

    send("illegal", 3'd7, 1'b0, 1'b0, n);
    idle("illegal_tail", 3, 1'b0, 1'b0);
    send("nop", 3'd0, 1'b0, 1'b0, n);
    idle("nop_tail", 3, 1'b0, 1'b0);

    send("add_abort", 3'd3, 1'b1, 1'b0, n);
    step("add_abort_rst", 1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
    idle("post_rst", 3, 1'b0, 1'b0);
    send("lda_after_rst", 3'd1, 1'b0, 1'b0, n);
    idle("lda_after_rst_tail", 3, 1'b0, 1'b0);

    for (int i = 0; i < 600; i++) begin
      step("rand", ($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    idle("final", 8, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
